framestore_request: RTL and testbench

- Framestore-side servicing engine for the framestore reader/writer fifos. It drains two reader address fifos and one writer fifo.
- Arbitrates round-robin between them and issues single 64-bit read/write commands to the memory controller.
- Routes in-order read responses back into the requesting reader's data fifo.
- Sits between the reader/writer fifo pairs and the memory controller; runs entirely on one clock.

---
 rtl/framestore_request.sv | 202 ++++++++++++++++++++
 tb/tb_framestore_request.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framestore_request.sv
// Framestore servicing engine: round-robin drain of two reader address fifos and
// one writer fifo into single 64-bit memory commands, with in-order read return.
module framestore_request #(
  parameter logic [3:0] max_outstanding = 4'd8,
  parameter logic [3:0] reader_credit   = 4'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd0_addr_empty,
  output logic        rd0_addr_en,
  input  logic        rd0_addr_valid,
  input  logic [21:0] rd0_addr,
  input  logic        rd0_dta_almost_full,
  output logic        rd0_dta_en,
  output logic [63:0] rd0_dta,
  input  logic        rd1_addr_empty,
  output logic        rd1_addr_en,
  input  logic        rd1_addr_valid,
  input  logic [21:0] rd1_addr,
  input  logic        rd1_dta_almost_full,
  output logic        rd1_dta_en,
  output logic [63:0] rd1_dta,
  input  logic        wr_empty,
  output logic        wr_en,
  input  logic        wr_valid,
  input  logic [21:0] wr_addr,
  input  logic [63:0] wr_dta,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_wr,
  output logic [21:0] mem_cmd_addr,
  output logic [63:0] mem_cmd_dta,
  input  logic        mem_res_valid,
  input  logic [63:0] mem_res_dta,
  output logic        res_error
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
  typedef enum logic [1:0] {SRC_WR, SRC_RD0, SRC_RD1} src_t;

  state_t state, state_nxt;
  src_t   rr_ptr, src, grant_src, s0, s1, s2;
  logic   grant, grant_go, fetch_valid;
  logic [2:0] elig;

  logic [3:0] out0, out1, total_out;
  logic [7:0] tag_mem;
  logic [2:0] tag_wp, tag_rp;
  logic       tag_head, accept_rd, res_ok, res_bad;

  function automatic src_t next_src(input src_t s);
    case (s)
      SRC_WR:  next_src = SRC_RD0;
      SRC_RD0: next_src = SRC_RD1;
      default: next_src = SRC_WR;
    endcase
  endfunction

  // elig bit index equals the src_t encoding
  always_comb begin
    elig[0] = !wr_empty;
    elig[1] = !rd0_addr_empty && !rd0_dta_almost_full &&
              (out0 < reader_credit) && (total_out < max_outstanding);
    elig[2] = !rd1_addr_empty && !rd1_dta_almost_full &&
              (out1 < reader_credit) && (total_out < max_outstanding);
    s0 = rr_ptr;
    s1 = next_src(s0);
    s2 = next_src(s1);
    grant     = 1'b1;
    grant_src = s0;
    if (elig[s0])      grant_src = s0;
    else if (elig[s1]) grant_src = s1;
    else if (elig[s2]) grant_src = s2;
    else               grant     = 1'b0;
  end

  assign grant_go = (state == IDLE) && grant && rst;

  always_comb begin
    case (src)
      SRC_WR:  fetch_valid = wr_valid;
      SRC_RD0: fetch_valid = rd0_addr_valid;
      default: fetch_valid = rd1_addr_valid;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    rd0_addr_en = 1'b0;
    rd1_addr_en = 1'b0;
    case (state)
      IDLE: begin
        if (grant_go) begin
          state_nxt   = FETCH;
          wr_en       = (grant_src == SRC_WR);
          rd0_addr_en = (grant_src == SRC_RD0);
          rd1_addr_en = (grant_src == SRC_RD1);
        end
      end
      FETCH:   state_nxt = fetch_valid ? ISSUE : IDLE;
      ISSUE:   if (mem_cmd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_cmd_valid = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= SRC_WR;
      src          <= SRC_WR;
      mem_cmd_wr   <= 1'b0;
      mem_cmd_addr <= '0;
      mem_cmd_dta  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_go) begin
        rr_ptr <= next_src(grant_src);
        src    <= grant_src;
      end
      if (state == FETCH && fetch_valid) begin
        case (src)
          SRC_WR: begin
            mem_cmd_wr   <= 1'b1;
            mem_cmd_addr <= wr_addr;
            mem_cmd_dta  <= wr_dta;
          end
          SRC_RD0: begin
            mem_cmd_wr   <= 1'b0;
            mem_cmd_addr <= rd0_addr;
          end
          default: begin
            mem_cmd_wr   <= 1'b0;
            mem_cmd_addr <= rd1_addr;
          end
        endcase
      end
    end
  end

  // total_out doubles as the tag fifo fill level
  assign accept_rd = mem_cmd_valid && mem_cmd_ready && !mem_cmd_wr;
  assign res_ok    = mem_res_valid && (total_out != 4'd0);
  assign res_bad   = mem_res_valid && (total_out == 4'd0);
  assign tag_head  = tag_mem[tag_rp];

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_mem    <= '0;
      tag_wp     <= '0;
      tag_rp     <= '0;
      out0       <= '0;
      out1       <= '0;
      total_out  <= '0;
      rd0_dta_en <= 1'b0;
      rd1_dta_en <= 1'b0;
      rd0_dta    <= '0;
      rd1_dta    <= '0;
      res_error  <= 1'b0;
    end else begin
      if (accept_rd) begin
        tag_mem[tag_wp] <= (src == SRC_RD1);
        tag_wp          <= tag_wp + 3'd1;
      end
      if (res_ok) tag_rp <= tag_rp + 3'd1;

      case ({accept_rd && (src == SRC_RD0), res_ok && !tag_head})
        2'b10:   out0 <= out0 + 4'd1;
        2'b01:   out0 <= out0 - 4'd1;
        default: out0 <= out0;
      endcase
      case ({accept_rd && (src == SRC_RD1), res_ok && tag_head})
        2'b10:   out1 <= out1 + 4'd1;
        2'b01:   out1 <= out1 - 4'd1;
        default: out1 <= out1;
      endcase
      case ({accept_rd, res_ok})
        2'b10:   total_out <= total_out + 4'd1;
        2'b01:   total_out <= total_out - 4'd1;
        default: total_out <= total_out;
      endcase

      rd0_dta_en <= res_ok && !tag_head;
      rd1_dta_en <= res_ok && tag_head;
      if (res_ok && !tag_head) rd0_dta <= mem_res_dta;
      if (res_ok && tag_head)  rd1_dta <= mem_res_dta;
      res_error <= res_error | res_bad;
    end
  end

`ifdef CHECK
  always_ff @(posedge clk) begin
    if (rst && res_bad) begin
      $error("framestore_request: read response with no outstanding tag");
      $stop;
    end
  end
`endif

endmodule

// File: tb/tb_framestore_request.sv
// Self-checking bench for framestore_request: fifo and memory models, a read-data
// scoreboard, a vector table and sequences for arbitration, credit and reset corners.
module tb_framestore_request;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd0_addr_empty, rd0_addr_en, rd0_addr_valid, rd0_dta_almost_full, rd0_dta_en;
  logic [21:0] rd0_addr;
  logic [63:0] rd0_dta;
  logic        rd1_addr_empty, rd1_addr_en, rd1_addr_valid, rd1_dta_almost_full, rd1_dta_en;
  logic [21:0] rd1_addr;
  logic [63:0] rd1_dta;
  logic        wr_empty, wr_en, wr_valid;
  logic [21:0] wr_addr;
  logic [63:0] wr_dta;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_wr;
  logic [21:0] mem_cmd_addr;
  logic [63:0] mem_cmd_dta;
  logic        mem_res_valid;
  logic [63:0] mem_res_dta;
  logic        res_error;

  framestore_request #(.max_outstanding(4'd8), .reader_credit(4'd4)) dut (
    .clk(clk), .rst(rst),
    .rd0_addr_empty(rd0_addr_empty), .rd0_addr_en(rd0_addr_en), .rd0_addr_valid(rd0_addr_valid),
    .rd0_addr(rd0_addr), .rd0_dta_almost_full(rd0_dta_almost_full), .rd0_dta_en(rd0_dta_en),
    .rd0_dta(rd0_dta),
    .rd1_addr_empty(rd1_addr_empty), .rd1_addr_en(rd1_addr_en), .rd1_addr_valid(rd1_addr_valid),
    .rd1_addr(rd1_addr), .rd1_dta_almost_full(rd1_dta_almost_full), .rd1_dta_en(rd1_dta_en),
    .rd1_dta(rd1_dta),
    .wr_empty(wr_empty), .wr_en(wr_en), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_dta(wr_dta),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_wr(mem_cmd_wr),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_dta(mem_cmd_dta),
    .mem_res_valid(mem_res_valid), .mem_res_dta(mem_res_dta), .res_error(res_error)
  );

  typedef struct {logic [21:0] addr; logic [63:0] dta;} wr_ent_t;
  typedef struct {logic wr; logic [21:0] addr; logic [63:0] dta; int cyc;} cmd_t;
  typedef struct {logic rdr; logic [63:0] dta;} exp_t;
  typedef struct {logic [63:0] dta; int due;} pend_t;
  typedef struct {int src; logic [21:0] addr; logic [63:0] dta; logic exp_wr;} vec_t;

  // Address map used by the bench: rd0 22'h0xxxxx, rd1 22'h1xxxxx, writer 22'h2xxxxx+
  logic [21:0] q0[$], q1[$];
  wr_ent_t     qw[$];
  cmd_t        log_q[$];
  exp_t        sb[$];
  pend_t       pend[$];
  logic [63:0] ovr[$];
  int          strobe_cyc[$];

  int   cyc = 0, n_chk = 0, n_fail = 0, grant_cyc = 0, resp_lat = 1;
  logic resp_hold = 1'b0, inject = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rdata(input logic [21:0] a);
    rdata = {16'hC0DE, 6'b0, a, 20'h5A5A5};
  endfunction

  task automatic strobe(input logic rdr, input logic [63:0] d);
    exp_t e;
    strobe_cyc.push_back(cyc);
    chk("strobe_expected", 64'(sb.size() > 0), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("strobe_reader", 64'(rdr), 64'(e.rdr));
      chk("strobe_data", d, e.dta);
    end
  endtask

  // One clock: sample DUT at negedge, drive fifo/memory models #1 after posedge
  task automatic tick();
    logic e0, e1, ew;
    cmd_t c;
    exp_t e;
    pend_t p;
    wr_ent_t w;
    logic [63:0] d;
    @(negedge clk);
    cyc++;
    if (mem_cmd_valid && mem_cmd_ready) begin
      c.wr = mem_cmd_wr; c.addr = mem_cmd_addr; c.dta = mem_cmd_dta; c.cyc = cyc;
      log_q.push_back(c);
      if (!mem_cmd_wr) begin
        if (ovr.size() > 0) d = ovr.pop_front();
        else d = rdata(mem_cmd_addr);
        e.rdr = mem_cmd_addr[20]; e.dta = d;
        sb.push_back(e);
        p.dta = d; p.due = cyc + resp_lat;
        pend.push_back(p);
      end
    end
    if (rd0_dta_en) strobe(1'b0, rd0_dta);
    if (rd1_dta_en) strobe(1'b1, rd1_dta);
    e0 = rd0_addr_en; e1 = rd1_addr_en; ew = wr_en;
    if (e0 || e1 || ew) grant_cyc = cyc;
    @(posedge clk);
    #1;
    rd0_addr_valid = 1'b0; rd1_addr_valid = 1'b0; wr_valid = 1'b0; mem_res_valid = 1'b0;
    if (e0 && q0.size() > 0) begin rd0_addr_valid = 1'b1; rd0_addr = q0.pop_front(); end
    if (e1 && q1.size() > 0) begin rd1_addr_valid = 1'b1; rd1_addr = q1.pop_front(); end
    if (ew && qw.size() > 0) begin
      w = qw.pop_front();
      wr_valid = 1'b1; wr_addr = w.addr; wr_dta = w.dta;
    end
    if (inject) begin
      mem_res_valid = 1'b1; mem_res_dta = 64'hBAD0_BAD0_BAD0_BAD0; inject = 1'b0;
    end else if (!resp_hold && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_res_valid = 1'b1; mem_res_dta = pend[0].dta;
      pend.delete(0);
    end
    rd0_addr_empty = (q0.size() == 0);
    rd1_addr_empty = (q1.size() == 0);
    wr_empty       = (qw.size() == 0);
  endtask

  task automatic wait_log(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (log_q.size() < target && n < budget) begin tick(); n++; end
    chk(name, 64'(log_q.size()), 64'(target));
  endtask

  function automatic int count_reads(input int base, input logic rdr);
    int n;
    n = 0;
    for (int i = base; i < log_q.size(); i++)
      if (!log_q[i].wr && !log_q[i].addr[21] && log_q[i].addr[20] == rdr) n++;
    return n;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"}, 64'(mem_cmd_valid), 64'(0));
    chk({tag, "_cmd_wr"},    64'(mem_cmd_wr), 64'(0));
    chk({tag, "_cmd_addr"},  64'(mem_cmd_addr), 64'(0));
    chk({tag, "_cmd_dta"},   mem_cmd_dta, 64'(0));
    chk({tag, "_pops"},      64'({wr_en, rd0_addr_en, rd1_addr_en}), 64'(0));
    chk({tag, "_dta_en"},    64'({rd0_dta_en, rd1_dta_en}), 64'(0));
    chk({tag, "_rd0_dta"},   rd0_dta, 64'(0));
    chk({tag, "_rd1_dta"},   rd1_dta, 64'(0));
    chk({tag, "_res_error"}, 64'(res_error), 64'(0));
  endtask

  // Holds responses, offers 6 addresses to one reader: the credit allows exactly 4
  task automatic credit_run(input logic rdr, input string name);
    int base;
    base = log_q.size();
    resp_hold = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (rdr) q1.push_back(22'h100200 + 22'(k));
      else     q0.push_back(22'h000200 + 22'(k));
    end
    repeat (30) tick();
    chk(name, 64'(count_reads(base, rdr)), 64'(4));
    chk({name, "_left"}, 64'(rdr ? q1.size() : q0.size()), 64'(2));
  endtask

  initial begin
    vec_t        vt[6];
    logic [21:0] rr_exp[6];
    int          base, s0, n;
    logic [21:0] bp_addr;
    logic [63:0] bp_dta;

    rst = 1'b0;
    rd0_addr_empty = 1'b1; rd0_addr_valid = 1'b0; rd0_addr = '0; rd0_dta_almost_full = 1'b0;
    rd1_addr_empty = 1'b1; rd1_addr_valid = 1'b0; rd1_addr = '0; rd1_dta_almost_full = 1'b0;
    wr_empty = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_dta = '0;
    mem_cmd_ready = 1'b1; mem_res_valid = 1'b0; mem_res_dta = '0;

    vt[0] = '{1, 22'h000123, 64'hA5A5_0000_1111_2222, 1'b0};
    vt[1] = '{0, 22'h2ABCDE, 64'h0123_4567_89AB_CDEF, 1'b1};
    vt[2] = '{2, 22'h100456, 64'h5A5A_FFFF_0000_1234, 1'b0};
    vt[3] = '{0, 22'h3FFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vt[4] = '{1, 22'h0FFFFF, 64'h0000_0000_0000_0000, 1'b0};
    vt[5] = '{2, 22'h100000, 64'h8000_0000_0000_0001, 1'b0};

    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    foreach (vt[i]) begin
      base = log_q.size();
      case (vt[i].src)
        0:       qw.push_back('{vt[i].addr, vt[i].dta});
        1:       begin q0.push_back(vt[i].addr); ovr.push_back(vt[i].dta); end
        default: begin q1.push_back(vt[i].addr); ovr.push_back(vt[i].dta); end
      endcase
      wait_log(base + 1, 20, "vec_issue");
      if (log_q.size() > base) begin
        chk("vec_wr", 64'(log_q[base].wr), 64'(vt[i].exp_wr));
        chk("vec_addr", 64'(log_q[base].addr), 64'(vt[i].addr));
        if (vt[i].exp_wr) chk("vec_dta", log_q[base].dta, vt[i].dta);
        chk("vec_latency", 64'(log_q[base].cyc - grant_cyc), 64'(2));
      end
      repeat (6) tick();
      chk("vec_drained", 64'(sb.size()), 64'(0));
    end

    // Round-robin from reset: pointer starts at the writer
    rst = 1'b0; tick(); rst = 1'b1;
    base = log_q.size();
    for (int k = 0; k < 2; k++) begin
      qw.push_back('{22'h200010 + 22'(k), 64'h1111_0000_0000_0000 + 64'(k)});
      q0.push_back(22'h000010 + 22'(k));
      q1.push_back(22'h100010 + 22'(k));
    end
    rr_exp[0] = 22'h200010; rr_exp[1] = 22'h000010; rr_exp[2] = 22'h100010;
    rr_exp[3] = 22'h200011; rr_exp[4] = 22'h000011; rr_exp[5] = 22'h100011;
    wait_log(base + 6, 40, "rr_issue");
    if (log_q.size() >= base + 6)
      for (int i = 0; i < 6; i++) begin
        chk("rr_order", 64'(log_q[base + i].addr), 64'(rr_exp[i]));
        if (i > 0) chk("rr_spacing", 64'(log_q[base + i].cyc - log_q[base + i - 1].cyc), 64'(3));
      end
    repeat (10) tick();
    chk("rr_drained", 64'(sb.size()), 64'(0));

    // Backpressure: command held stable while ready is low
    bp_addr = 22'h2B0000; bp_dta = 64'hDEAD_BEEF_0000_0001;
    mem_cmd_ready = 1'b0;
    base = log_q.size();
    qw.push_back('{bp_addr, bp_dta});
    n = 0;
    while (!mem_cmd_valid && n < 10) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(mem_cmd_valid), 64'(1));
      chk("bp_addr", 64'(mem_cmd_addr), 64'(bp_addr));
      chk("bp_dta", mem_cmd_dta, bp_dta);
      chk("bp_wr", 64'(mem_cmd_wr), 64'(1));
      tick();
    end
    mem_cmd_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 64'(mem_cmd_valid), 64'(0));
    repeat (5) tick();
    chk("bp_once", 64'(log_q.size() - base), 64'(1));

    // Accepts coinciding with responses: same reader, then alternating readers
    resp_lat = 2;
    base = log_q.size();
    for (int k = 0; k < 6; k++) q0.push_back(22'h000400 + 22'(k));
    wait_log(base + 6, 60, "coinc_same_issue");
    base = log_q.size();
    for (int k = 0; k < 6; k++) begin
      q0.push_back(22'h000500 + 22'(k));
      q1.push_back(22'h100500 + 22'(k));
    end
    wait_log(base + 12, 100, "coinc_mixed_issue");
    repeat (10) tick();
    chk("coinc_drained", 64'(sb.size()), 64'(0));
    resp_lat = 1;

    // Credit limits: counters must be back at zero, total reaches 8
    credit_run(1'b0, "credit_rd0");
    credit_run(1'b1, "credit_rd1");

    // Almost-full blocks rd0 while rd1 continues; release restores rd0
    rd0_dta_almost_full = 1'b1;
    base = log_q.size();
    resp_hold = 1'b0;
    repeat (40) tick();
    chk("af_blocks_rd0", 64'(count_reads(base, 1'b0)), 64'(0));
    chk("af_rd1_served", 64'(count_reads(base, 1'b1)), 64'(2));
    rd0_dta_almost_full = 1'b0;
    repeat (30) tick();
    chk("af_release_rd0", 64'(count_reads(base, 1'b0)), 64'(2));
    chk("af_drained", 64'(sb.size()), 64'(0));

    // Interleaved in-order return, back-to-back
    resp_hold = 1'b1;
    ovr.push_back(64'hD1D1_D1D1_0000_0001);
    ovr.push_back(64'hD2D2_D2D2_0000_0002);
    ovr.push_back(64'hD3D3_D3D3_0000_0003);
    base = log_q.size();
    q0.push_back(22'h000300); wait_log(base + 1, 20, "inter_issue0");
    q1.push_back(22'h100300); wait_log(base + 2, 20, "inter_issue1");
    q0.push_back(22'h000301); wait_log(base + 3, 20, "inter_issue2");
    s0 = strobe_cyc.size();
    resp_hold = 1'b0;
    repeat (8) tick();
    chk("inter_strobes", 64'(strobe_cyc.size() - s0), 64'(3));
    if (strobe_cyc.size() >= s0 + 3) begin
      chk("inter_b2b_1", 64'(strobe_cyc[s0 + 1] - strobe_cyc[s0]), 64'(1));
      chk("inter_b2b_2", 64'(strobe_cyc[s0 + 2] - strobe_cyc[s0 + 1]), 64'(1));
    end
    chk("inter_hold_rd0", rd0_dta, 64'hD3D3_D3D3_0000_0003);
    chk("inter_hold_rd1", rd1_dta, 64'hD2D2_D2D2_0000_0002);

    // Response with nothing outstanding
    inject = 1'b1;
    repeat (3) tick();
    chk("res_error_set", 64'(res_error), 64'(1));
    repeat (5) tick();
    chk("res_error_sticky", 64'(res_error), 64'(1));

    // Reset in the middle of ISSUE
    mem_cmd_ready = 1'b0;
    qw.push_back('{22'h2C0000, 64'h0F0F_0F0F_0F0F_0F0F});
    n = 0;
    while (!mem_cmd_valid && n < 10) begin tick(); n++; end
    chk("rst_reach_issue", 64'(mem_cmd_valid), 64'(1));
    rst = 1'b0;
    tick();
    check_reset_outputs("rst_mid");
    rst = 1'b1;
    mem_cmd_ready = 1'b1;
    base = log_q.size();
    repeat (5) tick();
    chk("rst_no_issue", 64'(log_q.size()), 64'(base));
    chk("rst_idle_valid", 64'(mem_cmd_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
